fb_text_writer: RTL and testbench

// - Producer side of the framebuffer write port (fb_data/fb_addr/fb_we) consumed by vga_controller.
// - Turns a byte stream of ASCII characters (valid/ready) into text-mode framebuffer writes.
// - Keeps the cursor, handles CR/LF/BS, auto-wraps, and clears lines and the screen.
// - Sits between a CPU/UART character source and the VGA framebuffer, for console output without CPU address math.

---
 rtl/fb_text_pkg.sv | 23 ++
 rtl/fb_fill_counter.sv | 51 +++++
 rtl/fb_text_writer.sv | 200 ++++++++++++++++++++
 tb/tb_fb_text_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_text_pkg.sv
// Shared types and constants for the framebuffer text writer.
//   fbtw_state_t : writer FSM state encoding
//   ASCII_*      : control characters the writer interprets
//   PRINT_LO/HI  : inclusive range of bytes written to the screen as glyphs
package fb_text_pkg;

  typedef enum logic [1:0] {
    CLR_SCREEN,
    IDLE,
    CLR_LINE
  } fbtw_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/fb_fill_counter.sv
// Sequential address generator for block fills of the framebuffer.
//   clk50, rst_n : clock, async active-low reset
//   start        : load base/length and begin emitting addresses next cycle
//   base         : first address of the fill
//   length       : number of addresses to emit (must be non-zero)
//   addr         : current fill address, valid while run is high
//   run          : one address emitted per cycle while high
//   done         : high during the cycle that emits the final address
// Out of reset the counter is already loaded for a full-screen fill starting
// at address 0, so the power-on clear needs no extra start cycle and a reset
// in the middle of any fill restarts the screen clear from the beginning.
module fb_fill_counter #(
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 12,
  parameter int RST_LEN = 2400
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] addr,
  output logic              run,
  output logic              done
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              run_q;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= LEN_W'(RST_LEN);
      run_q    <= 1'b1;
    end else if (start) begin
      addr_q   <= base;
      remain_q <= length;
      run_q    <= (length != '0);
    end else if (run_q) begin
      addr_q   <= addr_q + 1'b1;
      remain_q <= remain_q - 1'b1;
      if (remain_q == LEN_W'(1)) run_q <= 1'b0;
    end
  end

  assign addr = addr_q;
  assign run  = run_q;
  assign done = run_q && (remain_q == LEN_W'(1));

endmodule

// File: rtl/fb_text_writer.sv
// Text-mode console front end for the VGA framebuffer write port.
// Accepts ASCII bytes over valid/ready, keeps a cursor, handles CR/LF/BS,
// wraps at the right margin and row bottom, and clears lines/screen.
//   clk50, rst_n          : clock, async active-low reset
//   char_data/valid/ready : byte stream from the CPU/UART source
//   clear_req             : full clear + cursor home, honoured only in IDLE
//   fb_data/addr/we       : registered framebuffer write port
//   busy                  : high while a screen or line clear runs
//   cursor_col/row        : current cursor position
//
// state      | meaning
// CLR_SCREEN | filling every cell with CLEAR_CHAR, then homing the cursor
// IDLE       | accepting characters
// CLR_LINE   | filling the row the cursor just moved onto with CLEAR_CHAR
module fb_text_writer
  import fb_text_pkg::*;
#(
  parameter int                COLS       = 80,
  parameter int                ROWS       = 30,
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = DATA_W'(8'h20)
) (
  input  logic                     clk50,
  input  logic                     rst_n,
  input  logic [7:0]               char_data,
  input  logic                     char_valid,
  output logic                     char_ready,
  input  logic                     clear_req,
  output logic [DATA_W-1:0]        fb_data,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic                     fb_we,
  output logic                     busy,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row
);

  localparam int COL_W      = $clog2(COLS);
  localparam int ROW_W      = $clog2(ROWS);
  localparam int SCREEN_LEN = COLS * ROWS;
  localparam int LEN_W      = $clog2(SCREEN_LEN + 1);

  generate
    if (SCREEN_LEN > (2 ** ADDR_W)) begin : g_size_check
      $error("fb_text_writer: COLS*ROWS does not fit in ADDR_W address bits");
    end
  endgenerate

  fbtw_state_t state_q, state_d;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [LEN_W-1:0]  fill_len;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_run;
  logic              fill_done;

  logic              newline;
  logic [ROW_W-1:0]  row_nxt;
  logic [ADDR_W-1:0] base_nxt;
  logic              last_row;

  fb_fill_counter #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .RST_LEN (SCREEN_LEN)
  ) u_fill (
    .clk50  (clk50),
    .rst_n  (rst_n),
    .start  (fill_start),
    .base   (fill_base),
    .length (fill_len),
    .addr   (fill_addr),
    .run    (fill_run),
    .done   (fill_done)
  );

  assign char_ready = (state_q == IDLE) && !clear_req;
  assign busy       = (state_q != IDLE);

  // Row below the cursor, wrapping to the top row; line_base follows by
  // stepping COLS so fb_addr never needs a multiply.
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign row_nxt  = last_row ? '0 : row_q + 1'b1;
  assign base_nxt = last_row ? '0 : base_q + ADDR_W'(COLS);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_len   = LEN_W'(COLS);
    newline    = 1'b0;

    case (state_q)
      CLR_SCREEN: begin
        we_d   = fill_run;
        addr_d = fill_addr;
        data_d = CLEAR_CHAR;
        if (fill_done) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end
      end

      CLR_LINE: begin
        we_d   = fill_run;
        addr_d = fill_addr;
        data_d = CLEAR_CHAR;
        if (fill_done) state_d = IDLE;
      end

      IDLE: begin
        if (clear_req) begin
          state_d    = CLR_SCREEN;
          fill_start = 1'b1;
          fill_base  = '0;
          fill_len   = LEN_W'(SCREEN_LEN);
        end else if (char_valid) begin
          if (is_printable(char_data)) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_W'(col_q);
            data_d = DATA_W'(char_data);
            if (col_q == COL_W'(COLS - 1)) newline = 1'b1;
            else                           col_d   = col_q + 1'b1;
          end else if (char_data == ASCII_LF) begin
            newline = 1'b1;
          end else if (char_data == ASCII_CR) begin
            col_d = '0;
          end else if (char_data == ASCII_BS) begin
            // No reverse wrap: backspace at column 0 does nothing.
            if (col_q != '0) begin
              col_d  = col_q - 1'b1;
              we_d   = 1'b1;
              addr_d = base_q + ADDR_W'(col_q - 1'b1);
              data_d = CLEAR_CHAR;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (newline) begin
      col_d      = '0;
      row_d      = row_nxt;
      base_d     = base_nxt;
      state_d    = CLR_LINE;
      fill_start = 1'b1;
      fill_base  = base_nxt;
      fill_len   = LEN_W'(COLS);
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state_q <= CLR_SCREEN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_fb_text_writer.sv
module tb_fb_text_writer;
  import fb_text_pkg::*;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        clear_req;
  logic [7:0]  fb_data;
  logic [11:0] fb_addr;
  logic        fb_we;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  fb_text_writer dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .fb_data    (fb_data),
    .fb_addr    (fb_addr),
    .fb_we      (fb_we),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  n_writes = 0;
  int  m_col, m_row, m_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 12'(a);
    e.d = d;
    sb.push_back(e);
  endfunction

  function automatic void push_screen();
    for (int i = 0; i < 2400; i++) push_wr(i, 8'h20);
    m_col = 0; m_row = 0; m_base = 0;
  endfunction

  function automatic void model_newline();
    m_col = 0;
    if (m_row == 29) begin m_row = 0; m_base = 0; end
    else begin m_row++; m_base += 80; end
    for (int i = 0; i < 80; i++) push_wr(m_base + i, 8'h20);
  endfunction

  function automatic void model_accept(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(m_base + m_col, c);
      if (m_col == 79) model_newline();
      else m_col++;
    end else if (c == 8'h0A) model_newline();
    else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h08) begin
      if (m_col > 0) begin m_col--; push_wr(m_base + m_col, 8'h20); end
    end
  endfunction

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk50) begin
    if (rst_n === 1'b1 && fb_we === 1'b1) begin
      wr_t e;
      n_writes++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_write observed_addr=%0h observed_data=%0h expected=none",
               fb_addr, fb_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_addr", 32'(fb_addr), 32'(e.a));
        chk("sb_data", 32'(fb_data), 32'(e.d));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic put(input logic [7:0] c);
    int n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      @(negedge clk50);
      n++;
    end
    chk("put_ready_timeout", 32'(n >= 5000), 32'd0);
    char_data  = c;
    char_valid = 1'b1;
    model_accept(c);
    @(posedge clk50);
    @(negedge clk50);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int cycles, output int ready_hi);
    cycles = 0;
    ready_hi = 0;
    while (busy === 1'b1 && cycles < limit) begin
      if (char_ready !== 1'b0) ready_hi++;
      @(negedge clk50);
      cycles++;
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk50);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rh;
    rst_n      = 1'b0;
    char_data  = 8'h00;
    char_valid = 1'b0;
    clear_req  = 1'b0;
    #5;
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_data", 32'(fb_data), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    push_screen();
    @(negedge clk50);
    rst_n = 1'b1;
    wait_idle(3000, cyc, rh);
    chk("init_busy_drop", 32'(busy), 32'd0);
    drain("init_sb_empty");
    chk("init_write_count", 32'(n_writes), 32'd2400);
    chk("init_ready", 32'(char_ready), 32'd1);
    chk("init_col", 32'(cursor_col), 32'd0);
    chk("init_row", 32'(cursor_row), 32'd0);

    // "AB" back to back: writes on consecutive cycles
    put(8'h41);
    chk("ab_we0", 32'(fb_we), 32'd1);
    chk("ab_addr0", 32'(fb_addr), 32'd0);
    put(8'h42);
    chk("ab_we1", 32'(fb_we), 32'd1);
    chk("ab_addr1", 32'(fb_addr), 32'd1);
    chk("ab_data1", 32'(fb_data), 32'h42);
    chk("ab_col", 32'(cursor_col), 32'd2);

    // Move to (5,3), then LF
    put(8'h0D);
    repeat (3) put(8'h0A);
    put(8'h48); put(8'h45); put(8'h4C); put(8'h4C); put(8'h4F);
    chk("pre_lf_col", 32'(cursor_col), 32'd5);
    chk("pre_lf_row", 32'(cursor_row), 32'd3);
    put(8'h0A);
    chk("lf_no_write", 32'(fb_we), 32'd0);
    chk("lf_col", 32'(cursor_col), 32'd0);
    chk("lf_row", 32'(cursor_row), 32'd4);
    chk("lf_first_base", 32'(m_base), 32'd320);
    wait_idle(500, cyc, rh);
    chk("lf_busy_cycles", 32'(cyc), 32'd80);
    chk("lf_ready_low", 32'(rh), 32'd0);
    drain("lf_sb_empty");

    // Move to (79,29), then a printable that wraps everything
    repeat (25) put(8'h0A);
    for (int i = 0; i < 79; i++) put(8'h61 + 8'(i % 26));
    chk("pre_wrap_col", 32'(cursor_col), 32'd79);
    chk("pre_wrap_row", 32'(cursor_row), 32'd29);
    put(8'h5A);
    chk("wrap_we", 32'(fb_we), 32'd1);
    chk("wrap_addr", 32'(fb_addr), 32'd2399);
    chk("wrap_data", 32'(fb_data), 32'h5A);
    chk("wrap_col", 32'(cursor_col), 32'd0);
    chk("wrap_row", 32'(cursor_row), 32'd0);
    wait_idle(500, cyc, rh);
    chk("wrap_clear_cycles", 32'(cyc), 32'd80);
    drain("wrap_sb_empty");

    // Backspace at column 0, then mid-line; other control bytes
    put(8'h0A); put(8'h0A);
    put(8'h08);
    chk("bs0_no_write", 32'(fb_we), 32'd0);
    chk("bs0_col", 32'(cursor_col), 32'd0);
    chk("bs0_row", 32'(cursor_row), 32'd2);
    put(8'h61); put(8'h62); put(8'h63);
    put(8'h08);
    chk("bs_we", 32'(fb_we), 32'd1);
    chk("bs_addr", 32'(fb_addr), 32'd162);
    chk("bs_data", 32'(fb_data), 32'h20);
    chk("bs_col", 32'(cursor_col), 32'd2);
    chk("bs_row", 32'(cursor_row), 32'd2);
    put(8'h01);
    chk("junk_no_write", 32'(fb_we), 32'd0);
    chk("junk_col", 32'(cursor_col), 32'd2);
    put(8'h0D);
    chk("cr_no_write", 32'(fb_we), 32'd0);
    chk("cr_col", 32'(cursor_col), 32'd0);
    drain("bs_sb_empty");

    // clear_req wins over char_valid
    char_data  = 8'h51;
    char_valid = 1'b1;
    clear_req  = 1'b1;
    #1;
    chk("clr_ready_low", 32'(char_ready), 32'd0);
    push_screen();
    @(posedge clk50);
    @(negedge clk50);
    clear_req  = 1'b0;
    char_valid = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    wait_idle(3000, cyc, rh);
    chk("clr_busy_drop", 32'(busy), 32'd0);
    drain("clr_sb_empty");
    chk("clr_col", 32'(cursor_col), 32'd0);
    chk("clr_row", 32'(cursor_row), 32'd0);

    // Reset in the middle of a screen clear
    clear_req = 1'b1;
    push_screen();
    @(posedge clk50);
    @(negedge clk50);
    clear_req = 1'b0;
    repeat (100) @(negedge clk50);
    chk("mid_clear_we", 32'(fb_we), 32'd1);
    @(posedge clk50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(fb_we), 32'd0);
    chk("midrst_addr", 32'(fb_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ready", 32'(char_ready), 32'd0);
    sb.delete();
    push_screen();
    n_writes = 0;
    @(negedge clk50);
    rst_n = 1'b1;
    wait_idle(3000, cyc, rh);
    chk("midrst_busy_drop", 32'(busy), 32'd0);
    drain("midrst_sb_empty");
    chk("midrst_write_count", 32'(n_writes), 32'd2400);
    chk("midrst_col", 32'(cursor_col), 32'd0);
    chk("midrst_row", 32'(cursor_row), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
